led_matrix_scanner: RTL and testbench



---
 rtl/led_matrix_scanner.sv | 69 ++++++
 tb/tb_led_matrix_scanner.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner: double-buffered 16x16 frame store scanned onto LED row/column pins
module led_matrix_scanner #(
  parameter logic        ROW_ACTIVE   = 1'b1,
  parameter logic        COL_ACTIVE   = 1'b0,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Scan_tick,
  input  logic        Wr_en,
  input  logic [3:0]  Wr_row,
  input  logic [15:0] Wr_data,
  input  logic        Commit,
  output logic        Ready,
  output logic        Swap_ack,
  output logic        Frame_done,
  output logic [15:0] Array_row,
  output logic [15:0] Array_col
);
  logic [15:0] bank [2][16];
  logic        front, pending, wrap, swap, next_front;
  logic [3:0]  row_idx, next_row, blank_cnt;
  localparam logic [15:0] COL_OFF = {16{~COL_ACTIVE}};
  function automatic logic [15:0] col_drive(input logic [15:0] d);
    return {16{COL_ACTIVE}} ~^ d;
  endfunction
  function automatic logic [15:0] row_drive(input logic [3:0] r);
    return {16{ROW_ACTIVE}} ~^ (16'd1 << r);
  endfunction
  always_comb begin
    next_row   = row_idx + 4'd1;
    wrap       = Scan_tick && (row_idx == 4'd15);
    swap       = wrap && pending;
    next_front = front ^ swap;
  end
  assign Ready = ~pending;
  // Writes go to the back bank; a swap can only happen while pending, when writes are blocked,
  // so the bank being displayed is never written in the same cycle it is read.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < 16; r++)
          bank[b][r] <= '0;
      front      <= 1'b0;
      pending    <= 1'b0;
      row_idx    <= '0;
      blank_cnt  <= '0;
      Swap_ack   <= 1'b0;
      Frame_done <= 1'b0;
      Array_row  <= row_drive(4'd0);
      Array_col  <= COL_OFF;
    end else begin
      if (Wr_en && !pending) bank[~front][Wr_row] <= Wr_data;
      pending    <= swap ? 1'b0 : (pending | Commit);
      front      <= next_front;
      Swap_ack   <= swap;
      Frame_done <= wrap;
      if (Scan_tick) begin
        row_idx   <= next_row;
        Array_row <= row_drive(next_row);
        blank_cnt <= 4'(BLANK_CYCLES);
        Array_col <= (BLANK_CYCLES == 0) ? col_drive(bank[next_front][next_row]) : COL_OFF;
      end else begin
        blank_cnt <= (blank_cnt != 4'd0) ? blank_cnt - 4'd1 : 4'd0;
        Array_col <= (blank_cnt <= 4'd1) ? col_drive(bank[front][row_idx]) : COL_OFF;
      end
    end
  end
endmodule

// File: tb/tb_led_matrix_scanner.sv
// tb_led_matrix_scanner: directed self-checking bench for led_matrix_scanner (default parameters)
module tb_led_matrix_scanner;
  logic        Clk = 1'b0, Rst_n = 1'b0, Scan_tick = 1'b0, Wr_en = 1'b0, Commit = 1'b0;
  logic [3:0]  Wr_row = '0;
  logic [15:0] Wr_data = '0;
  logic        Ready, Swap_ack, Frame_done;
  logic [15:0] Array_row, Array_col;
  int total = 0, passed = 0, swaps = 0, frames = 0;

  led_matrix_scanner dut (
    .Clk(Clk), .Rst_n(Rst_n), .Scan_tick(Scan_tick), .Wr_en(Wr_en), .Wr_row(Wr_row),
    .Wr_data(Wr_data), .Commit(Commit), .Ready(Ready), .Swap_ack(Swap_ack),
    .Frame_done(Frame_done), .Array_row(Array_row), .Array_col(Array_col)
  );

  always #5 Clk = ~Clk;

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic ticks(input int n);
    swaps = 0;
    frames = 0;
    repeat (n) begin
      Scan_tick = 1'b1;
      cyc();
      Scan_tick = 1'b0;
      swaps += int'(Swap_ack);
      frames += int'(Frame_done);
    end
  endtask

  task automatic wr(input logic [3:0] r, input logic [15:0] d);
    Wr_en = 1'b1;
    Wr_row = r;
    Wr_data = d;
    cyc();
    Wr_en = 1'b0;
  endtask

  initial begin
    #23;
    chk("rst_row", Array_row, 16'h0001);
    chk("rst_col", Array_col, 16'hFFFF);
    chk("rst_ready", 16'(Ready), 16'd1);
    chk("rst_swap", 16'(Swap_ack), 16'd0);
    chk("rst_frame", 16'(Frame_done), 16'd0);
    Rst_n = 1'b1;
    cyc();
    // one full frame of ticks
    ticks(15);
    chk("idle_frames15", 16'(frames), 16'd0);
    chk("idle_row15", Array_row, 16'h8000);
    Scan_tick = 1'b1;
    cyc();
    Scan_tick = 1'b0;
    chk("idle_frame_done", 16'(Frame_done), 16'd1);
    chk("idle_row0", Array_row, 16'h0001);
    chk("idle_col", Array_col, 16'hFFFF);
    cyc();
    chk("idle_frame_pulse", 16'(Frame_done), 16'd0);
    // write two rows, commit, swap on wrap
    wr(4'd3, 16'h00F0);
    wr(4'd5, 16'hA5A5);
    Commit = 1'b1;
    cyc();
    Commit = 1'b0;
    chk("commit_ready", 16'(Ready), 16'd0);
    ticks(15);
    chk("commit_noswap", 16'(swaps), 16'd0);
    chk("commit_ready15", 16'(Ready), 16'd0);
    Scan_tick = 1'b1;
    cyc();
    Scan_tick = 1'b0;
    chk("wrap_swap", 16'(Swap_ack), 16'd1);
    chk("wrap_frame", 16'(Frame_done), 16'd1);
    chk("wrap_ready", 16'(Ready), 16'd1);
    cyc();
    chk("swap_pulse", 16'(Swap_ack), 16'd0);
    // single tick blanking on row 3
    ticks(2);
    ticks(1);
    chk("blank_row3", Array_row, 16'h0008);
    chk("blank_t1", Array_col, 16'hFFFF);
    cyc();
    chk("blank_t2", Array_col, 16'hFFFF);
    cyc();
    chk("data_t3", Array_col, 16'hFF0F);
    // back-to-back ticks restart blanking
    Scan_tick = 1'b1;
    cyc();
    chk("dbl_t1", Array_col, 16'hFFFF);
    cyc();
    Scan_tick = 1'b0;
    chk("dbl_row5", Array_row, 16'h0020);
    chk("dbl_t2", Array_col, 16'hFFFF);
    cyc();
    chk("dbl_t3", Array_col, 16'hFFFF);
    cyc();
    chk("dbl_t4", Array_col, 16'h5A5A);
    // write while pending is ignored
    wr(4'd7, 16'h0F0F);
    Commit = 1'b1;
    cyc();
    Commit = 1'b0;
    chk("pend_ready", 16'(Ready), 16'd0);
    wr(4'd7, 16'hFFFF);
    ticks(10);
    chk("pend_noswap", 16'(swaps), 16'd0);
    ticks(1);
    chk("pend_swap", 16'(swaps), 16'd1);
    ticks(7);
    cyc();
    cyc();
    chk("pend_row7", Array_row, 16'h0080);
    chk("pend_col7", Array_col, 16'hF0F0);
    // commit coincident with wrap tick waits a full frame
    ticks(8);
    chk("late_ready", 16'(Ready), 16'd1);
    Scan_tick = 1'b1;
    Commit = 1'b1;
    cyc();
    Scan_tick = 1'b0;
    Commit = 1'b0;
    chk("late_frame", 16'(Frame_done), 16'd1);
    chk("late_noswap", 16'(Swap_ack), 16'd0);
    chk("late_pending", 16'(Ready), 16'd0);
    ticks(15);
    chk("late_wait", 16'(swaps), 16'd0);
    ticks(1);
    chk("late_swap", 16'(swaps), 16'd1);
    chk("late_ready2", 16'(Ready), 16'd1);
    // async reset mid-frame with a swap pending
    wr(4'd9, 16'h1111);
    Commit = 1'b1;
    cyc();
    Commit = 1'b0;
    ticks(3);
    cyc();
    cyc();
    chk("pre_rst_col", Array_col, 16'hFF0F);
    #3 Rst_n = 1'b0;
    #1;
    chk("arst_row", Array_row, 16'h0001);
    chk("arst_col", Array_col, 16'hFFFF);
    chk("arst_ready", 16'(Ready), 16'd1);
    chk("arst_swap", 16'(Swap_ack), 16'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    cyc();
    ticks(3);
    cyc();
    cyc();
    chk("post_rst_row3", Array_row, 16'h0008);
    chk("post_rst_col3", Array_col, 16'hFFFF);
    chk("post_rst_ready", 16'(Ready), 16'd1);
    ticks(13);
    chk("post_rst_noswap", 16'(swaps), 16'd0);
    chk("post_rst_frame", 16'(frames), 16'd1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
